// File: rtl/rmw_table_pkg.sv
// ---------------------------------------------------------------------------
// rmw_table_pkg
// Shared definitions for the read-modify-write table:
//   - op_e      : request operation encoding (READ, ADD, COPY, CLEAR)
//   - state_e   : control FSM states (INIT clears the table, RUN serves requests)
//   - addr_width: index width for a given table depth
// ---------------------------------------------------------------------------
package rmw_table_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_ADD   = 2'd1,
        OP_COPY  = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Index width for a DEPTH-entry table; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage : rmw_table_pkg

// File: rtl/rmw_table_ram.sv
// ---------------------------------------------------------------------------
// rmw_table_ram
// DEPTH x WIDTH storage with one synchronous read port and one write port.
// A read of the address being written in the same cycle returns the new
// data, so a request in S0 always sees the write made by the request in S1.
//
// Ports:
//   clk        in   rising-edge clock
//   i_rd_en    in   load o_rd_data from i_rd_addr at the next edge
//   i_rd_addr  in   read index
//   o_rd_data  out  registered read data, held while i_rd_en is low
//   i_wr_en    in   write enable
//   i_wr_addr  in   write index
//   i_wr_data  in   write data
// ---------------------------------------------------------------------------
module rmw_table_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // NOTE: the array and its read register have no reset; a reset port on a
    // memory prevents mapping onto RAM macros. The owner clears it by writing.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            // Write-through forwarding: same-cycle write wins over stored data.
            if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
                r_rd_data <= i_wr_data;
            end else begin
                r_rd_data <= r_mem[i_rd_addr];
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : rmw_table_ram

// File: rtl/rmw_table.sv
// ---------------------------------------------------------------------------
// rmw_table
// Parametrised read-modify-write table. After reset an INIT phase writes 0 to
// every entry (DEPTH cycles); afterwards each accepted request does one read
// and at most one write through a 2-stage pipeline:
//   S0 (accept cycle): synchronous read of the source index, capture request.
//   S1 (next cycle)  : compute, write back, load the response register.
// S1 only advances when the response register is empty or being consumed, so
// at most two requests are in flight and nothing is lost under backpressure.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid && req_ready
//   req_op     in   0 READ, 1 ADD, 2 COPY, 3 CLEAR
//   req_addr   in   target index
//   req_data   in   addend for ADD
//   rsp_valid  out  response present
//   rsp_ready  in   response consumed when rsp_valid && rsp_ready
//   rsp_data   out  response value (old entry, or source value for COPY)
//   init_done  out  table initialised
// ---------------------------------------------------------------------------
module rmw_table
    import rmw_table_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int OFFSET   = 4,
    parameter int SATURATE = 0,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             init_done
);

    localparam int            OFFSET_MOD = OFFSET % DEPTH;
    localparam logic [AW-1:0] SRC_OFFSET = AW'(OFFSET_MOD);
    localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);

    // Control FSM
    state_e             r_state;
    state_e             w_state_nxt;
    logic [AW-1:0]      r_init_ptr;
    logic [AW-1:0]      w_init_ptr_nxt;

    // S1 pipeline register
    logic               r_s1_valid;
    op_e                r_s1_op;
    logic [AW-1:0]      r_s1_idx;
    logic [WIDTH-1:0]   r_s1_data;

    // Response register
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_data;

    // Datapath
    op_e                w_req_op;
    logic               w_accept;
    logic               w_s1_adv;
    logic [AW-1:0]      w_rd_idx;
    logic [WIDTH-1:0]   w_rd_data;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_add_res;
    logic [WIDTH-1:0]   w_s1_rsp;
    logic               w_s1_wr;
    logic [WIDTH-1:0]   w_s1_wr_data;
    logic               w_wr_en;
    logic [AW-1:0]      w_wr_addr;
    logic [WIDTH-1:0]   w_wr_data;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order blocks are evaluated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_ptr <= w_init_ptr_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and outputs
    // -----------------------------------------------------------------------
    // NOTE: every output of a combinational block is given a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_ptr_nxt = r_init_ptr;
        req_ready      = 1'b0;
        init_done      = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                w_init_ptr_nxt = r_init_ptr + 1'b1;
                if (r_init_ptr == LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
                // Only a stalled S1 (full response register not being drained)
                // blocks a new request; otherwise S1 frees up this cycle.
                req_ready = !(r_s1_valid && r_rsp_valid && !rsp_ready);
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // S0: accept and issue the read
    // -----------------------------------------------------------------------
    assign w_req_op = op_e'(req_op);
    assign w_accept = req_valid && req_ready;
    assign w_rd_idx = (w_req_op == OP_COPY) ? (req_addr + SRC_OFFSET) : req_addr;

    // -----------------------------------------------------------------------
    // S1: modify. w_rd_data is the entry read in S0; it is held by the RAM
    // while S1 stalls because no new read can be issued meanwhile.
    // -----------------------------------------------------------------------
    assign w_s1_adv = r_s1_valid && (!r_rsp_valid || rsp_ready);
    assign w_sum    = {1'b0, w_rd_data} + {1'b0, r_s1_data};

    always_comb begin
        w_add_res = w_sum[WIDTH-1:0];
        if ((SATURATE != 0) && w_sum[WIDTH]) begin
            w_add_res = '1;
        end
    end

    always_comb begin
        w_s1_wr      = 1'b0;
        w_s1_wr_data = '0;
        w_s1_rsp     = w_rd_data;
        unique case (r_s1_op)
            OP_READ: begin
                w_s1_wr = 1'b0;
            end
            OP_ADD: begin
                w_s1_wr      = 1'b1;
                w_s1_wr_data = w_add_res;
            end
            OP_COPY: begin
                w_s1_wr      = 1'b1;
                w_s1_wr_data = w_rd_data;
            end
            OP_CLEAR: begin
                w_s1_wr      = 1'b1;
                w_s1_wr_data = '0;
            end
            default: begin
                w_s1_wr = 1'b0;
            end
        endcase
    end

    // Write port: INIT owns it while clearing, then S1 writes as it advances.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_s1_idx;
        w_wr_data = w_s1_wr_data;
        if (r_state == ST_INIT) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_init_ptr;
            w_wr_data = '0;
        end else begin
            w_wr_en = w_s1_adv && w_s1_wr;
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= OP_READ;
            r_s1_idx    <= '0;
            r_s1_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= w_req_op;
                r_s1_idx   <= req_addr;
                r_s1_data  <= req_data;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_s1_rsp;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    rmw_table_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .i_rd_en   (w_accept),
        .i_rd_addr (w_rd_idx),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data)
    );

endmodule : rmw_table

// File: tb/tb_rmw_table.sv
// ---------------------------------------------------------------------------
// tb_rmw_table
// Drives a 32-bit, 8-entry table with directed and random request streams and
// compares every response against a reference table model kept here. Two
// extra 8-bit instances (saturating and wrapping) cover the ADD overflow rule.
// ---------------------------------------------------------------------------
module tb_rmw_table;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 8;
    localparam int OFFSET = 4;
    localparam int AW     = 3;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op    = 2'd0;
    logic [AW-1:0]    req_addr  = '0;
    logic [WIDTH-1:0] req_data  = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic             init_done;

    // Shared stimulus for the two 8-bit instances
    logic             n_req_valid = 1'b0;
    logic [1:0]       n_req_op    = 2'd0;
    logic [AW-1:0]    n_req_addr  = '0;
    logic [7:0]       n_req_data  = '0;
    logic             n_rsp_ready = 1'b1;
    logic             s_req_ready, w_req_ready;
    logic             s_rsp_valid, w_rsp_valid;
    logic [7:0]       s_rsp_data,  w_rsp_data;
    logic             s_init_done, w_init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rmw_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OFFSET(OFFSET), .SATURATE(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_done(init_done)
    );

    rmw_table #(.WIDTH(8), .DEPTH(DEPTH), .OFFSET(OFFSET), .SATURATE(1)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .req_valid(n_req_valid), .req_ready(s_req_ready), .req_op(n_req_op),
        .req_addr(n_req_addr), .req_data(n_req_data),
        .rsp_valid(s_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_data(s_rsp_data),
        .init_done(s_init_done)
    );

    rmw_table #(.WIDTH(8), .DEPTH(DEPTH), .OFFSET(OFFSET), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .req_valid(n_req_valid), .req_ready(w_req_ready), .req_op(n_req_op),
        .req_addr(n_req_addr), .req_data(n_req_data),
        .rsp_valid(w_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_data(w_rsp_data),
        .init_done(w_init_done)
    );

    // ---------------------------------------------------------------------
    // Reference model: the table as a plain array, requests applied in
    // acceptance order.
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] model_mem [DEPTH];

    function automatic logic [WIDTH-1:0] model_apply(input logic [1:0] op, input int addr,
                                                     input logic [WIDTH-1:0] data);
        logic [WIDTH-1:0] old;
        logic [WIDTH-1:0] src_val;
        logic [WIDTH-1:0] result;
        int               src;
        old     = model_mem[addr];
        src     = (addr + OFFSET) % DEPTH;
        src_val = model_mem[src];
        result  = old;
        case (op)
            2'd1: model_mem[addr] = old + data;
            2'd2: begin
                model_mem[addr] = src_val;
                result          = src_val;
            end
            2'd3: model_mem[addr] = '0;
            default: result = old;
        endcase
        return result;
    endfunction

    // Request list and collected results
    logic [1:0]       q_op   [$];
    int               q_addr [$];
    logic [WIDTH-1:0] q_data [$];
    logic [WIDTH-1:0] act_q  [$];
    logic [WIDTH-1:0] exp_q  [$];
    int               lat_q  [$];
    int               extra_rsp;
    int               stab_err;
    int               acc_in_hold;
    logic             rdy_after_hold;
    logic             timed_out;

    task automatic clear_list();
        q_op.delete();
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic add_req(input logic [1:0] op, input int addr, input logic [WIDTH-1:0] data);
        q_op.push_back(op);
        q_addr.push_back(addr);
        q_data.push_back(data);
    endtask

    // Drives the request list (called at a falling edge). rsp_ready is held
    // low for the first 'hold' cycles, then random with stall_pct % low.
    task automatic run_list(input int stall_pct, input int hold);
        int               idx;
        logic             held;
        logic [WIDTH-1:0] held_data;
        logic [WIDTH-1:0] pend_exp [$];
        int               pend_cyc [$];
        idx = 0;
        held = 1'b0;
        held_data = '0;
        act_q.delete();
        exp_q.delete();
        lat_q.delete();
        extra_rsp = 0;
        stab_err = 0;
        acc_in_hold = 0;
        rdy_after_hold = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (idx >= q_op.size() && pend_exp.size() == 0) break;
            req_valid = (idx < q_op.size());
            if (req_valid) begin
                req_op   = q_op[idx];
                req_addr = AW'(q_addr[idx]);
                req_data = q_data[idx];
            end
            rsp_ready = (c >= hold) && (int'($urandom_range(99)) >= stall_pct);
            #1;
            if (held && (!rsp_valid || rsp_data !== held_data)) stab_err++;
            if (rsp_valid && rsp_ready) begin
                if (pend_exp.size() == 0) begin
                    extra_rsp++;
                end else begin
                    act_q.push_back(rsp_data);
                    exp_q.push_back(pend_exp.pop_front());
                    lat_q.push_back(c - pend_cyc.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                pend_exp.push_back(model_apply(q_op[idx], q_addr[idx], q_data[idx]));
                pend_cyc.push_back(c);
                idx++;
                if (c < hold) acc_in_hold++;
            end
            if (hold > 0 && c == hold - 1) rdy_after_hold = req_ready;
            held      = rsp_valid && !rsp_ready;
            held_data = rsp_data;
            @(negedge clk);
        end
        timed_out = (idx < q_op.size()) || (pend_exp.size() != 0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
    endtask

    // Applies reset for 'hold' falling edges, releases it and waits (bounded)
    // for init_done, counting rising edges and any ready/response seen.
    task automatic do_reset(input int hold, output int n_init, output int rdy_err,
                            output int rsp_seen);
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        n_req_valid = 1'b0;
        #1;
        rsp_seen = rsp_valid ? 1 : 0;
        repeat (hold) @(negedge clk);
        reset_n = 1'b1;
        n_init  = 0;
        rdy_err = 0;
        #1;
        while (!init_done && n_init < 40) begin
            if (req_ready) rdy_err++;
            if (rsp_valid) rsp_seen++;
            @(negedge clk);
            #1;
            n_init++;
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        int n_init, rdy_err, rsp_seen;
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++;
        if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        do_reset(2, n_init, rdy_err, rsp_seen);
        checks++;
        if (n_init !== 8) begin errors++; $display("FAIL init_cycles: got %0d expected 8", n_init); end
        checks++;
        if (rdy_err !== 0) begin errors++; $display("FAIL init_req_ready: got %0d ready cycles expected 0", rdy_err); end
        checks++;
        if (rsp_seen !== 0) begin errors++; $display("FAIL init_rsp_valid: got %0d response cycles expected 0", rsp_seen); end
        checks++;
        if (s_init_done !== 1'b1 || w_init_done !== 1'b1) begin
            errors++; $display("FAIL init_done_8bit: got %b%b expected 11", s_init_done, w_init_done);
        end
    endtask

    task automatic test_read_all();
        clear_list();
        for (int i = 0; i < DEPTH; i++) add_req(2'd0, i, '0);
        run_list(0, 0);
        checks++;
        if (timed_out || act_q.size() != DEPTH) begin
            errors++; $display("FAIL read_all_count: got %0d responses expected %0d", act_q.size(), DEPTH);
        end
        foreach (act_q[i]) begin
            checks++;
            if (act_q[i] !== '0) begin errors++; $display("FAIL read_all_data[%0d]: got %0h expected 0", i, act_q[i]); end
            checks++;
            if (lat_q[i] !== 2) begin errors++; $display("FAIL read_all_latency[%0d]: got %0d expected 2", i, lat_q[i]); end
        end
    endtask

    task automatic test_add_accumulate();
        logic [WIDTH-1:0] want [4];
        want = '{32'd0, 32'd5, 32'd10, 32'd15};
        clear_list();
        repeat (3) add_req(2'd1, 3, 32'd5);
        add_req(2'd0, 3, '0);
        run_list(0, 0);
        checks++;
        if (timed_out || act_q.size() != 4) begin
            errors++; $display("FAIL add_acc_count: got %0d responses expected 4", act_q.size());
        end
        foreach (act_q[i]) begin
            checks++;
            if (act_q[i] !== want[i]) begin errors++; $display("FAIL add_acc_data[%0d]: got %0d expected %0d", i, act_q[i], want[i]); end
            checks++;
            if (lat_q[i] !== 2) begin errors++; $display("FAIL add_acc_latency[%0d]: got %0d expected 2", i, lat_q[i]); end
        end
    endtask

    task automatic test_add_copy();
        logic [WIDTH-1:0] want [3];
        want = '{32'd0, 32'd7, 32'd7};
        clear_list();
        add_req(2'd1, 1, 32'd7);
        add_req(2'd2, 5, '0);
        add_req(2'd0, 5, '0);
        run_list(0, 0);
        checks++;
        if (timed_out || act_q.size() != 3) begin
            errors++; $display("FAIL add_copy_count: got %0d responses expected 3", act_q.size());
        end
        foreach (act_q[i]) begin
            checks++;
            if (act_q[i] !== want[i]) begin errors++; $display("FAIL add_copy_data[%0d]: got %0d expected %0d", i, act_q[i], want[i]); end
        end
    endtask

    task automatic test_backpressure();
        clear_list();
        for (int i = 0; i < 6; i++) add_req(2'($urandom_range(3)), int'($urandom_range(DEPTH - 1)), $urandom());
        run_list(0, 10);
        checks++;
        if (acc_in_hold !== 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", acc_in_hold); end
        checks++;
        if (rdy_after_hold !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b expected 0", rdy_after_hold); end
        checks++;
        if (timed_out || act_q.size() != 6 || extra_rsp != 0) begin
            errors++; $display("FAIL bp_count: got %0d responses (%0d extra) expected 6", act_q.size(), extra_rsp);
        end
        checks++;
        if (stab_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stab_err); end
        foreach (act_q[i]) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, act_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        clear_list();
        for (int i = 0; i < 300; i++) begin
            add_req(2'($urandom_range(3)), int'($urandom_range(DEPTH - 1)),
                    ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(31)) : $urandom());
        end
        run_list(35, 0);
        checks++;
        if (timed_out || act_q.size() != 300 || extra_rsp != 0) begin
            errors++; $display("FAIL rand_count: got %0d responses (%0d extra) expected 300", act_q.size(), extra_rsp);
        end
        checks++;
        if (stab_err !== 0) begin errors++; $display("FAIL rand_stable: got %0d unstable cycles expected 0", stab_err); end
        foreach (act_q[i]) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %0h expected %0h", i, act_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] sat_rsp  [$];
        logic [7:0] wrap_rsp [$];
        int k;
        k = 0;
        for (int c = 0; c < 40 && (k < 3 || sat_rsp.size() < 3 || wrap_rsp.size() < 3); c++) begin
            n_req_valid = (k < 3);
            n_req_op    = (k == 2) ? 2'd0 : 2'd1;
            n_req_addr  = '0;
            n_req_data  = (k == 0) ? 8'd200 : 8'd100;
            #1;
            if (s_rsp_valid) sat_rsp.push_back(s_rsp_data);
            if (w_rsp_valid) wrap_rsp.push_back(w_rsp_data);
            if (n_req_valid && s_req_ready) k++;
            @(negedge clk);
        end
        n_req_valid = 1'b0;
        checks++;
        if (sat_rsp.size() != 3 || wrap_rsp.size() != 3) begin
            errors++; $display("FAIL sat_count: got %0d/%0d responses expected 3/3", sat_rsp.size(), wrap_rsp.size());
        end else begin
            checks++;
            if (sat_rsp[1] !== 8'd200) begin errors++; $display("FAIL sat_second_add: got %0d expected 200", sat_rsp[1]); end
            checks++;
            if (sat_rsp[2] !== 8'd255) begin errors++; $display("FAIL sat_read: got %0d expected 255", sat_rsp[2]); end
            checks++;
            if (wrap_rsp[2] !== 8'd44) begin errors++; $display("FAIL wrap_read: got %0d expected 44", wrap_rsp[2]); end
        end
    endtask

    task automatic test_reset_mid();
        int n_init, rdy_err, rsp_seen;
        logic accepted;
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_addr  = AW'(2);
        req_data  = 32'd9;
        rsp_ready = 1'b1;
        #1;
        accepted = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        do_reset(1, n_init, rdy_err, rsp_seen);
        checks++;
        if (accepted !== 1'b1) begin errors++; $display("FAIL mid_accept: got %b expected 1", accepted); end
        checks++;
        if (rsp_seen !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d response cycles expected 0", rsp_seen); end
        checks++;
        if (n_init !== 8) begin errors++; $display("FAIL mid_init_cycles: got %0d expected 8", n_init); end
        clear_list();
        add_req(2'd0, 2, '0);
        run_list(0, 0);
        checks++;
        if (timed_out || act_q.size() != 1) begin
            errors++; $display("FAIL mid_read_count: got %0d responses expected 1", act_q.size());
        end else begin
            checks++;
            if (act_q[0] !== '0) begin errors++; $display("FAIL mid_read_data: got %0h expected 0", act_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_add_accumulate();
        test_add_copy();
        test_backpressure();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_rmw_table

// File: doc/rmw_table.md
Name: rmw_table

Overview:
- Parametrised read-modify-write table: DEPTH entries, each WIDTH bits wide.
- Every request performs one table read and at most one write in a 2-stage pipeline.
- Requests and responses use valid/ready handshakes.
- Used for per-index counters and shifted-copy tables in datapath blocks. Supersedes the fixed 8x32 increment/copy memory.

Parameters:
- WIDTH, 32: entry and data width in bits.
- DEPTH, 8: number of entries. Power of 2, at least 2. AW = clog2(DEPTH).
- OFFSET, 4: source-index offset for COPY, taken mod DEPTH.
- SATURATE, 0: 1 = ADD clamps at 2^WIDTH-1; 0 = ADD wraps mod 2^WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_op  in  2  operation: 0 READ, 1 ADD, 2 COPY, 3 CLEAR.
- req_addr  in  AW  target index.
- req_data  in  WIDTH  addend for ADD; ignored for other ops.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_data  out  WIDTH  response value.
- init_done  out  1  table initialised.

Behaviour:
- Reset (reset_n low, asynchronous): state=INIT, init_ptr=0. Pipeline valids, rsp_valid, req_ready and init_done all 0. rsp_data resets to 0. Table contents are not reset by the flop reset.
- FSM INIT:
  - Writes 0 to entry init_ptr each cycle and increments init_ptr.
  - Moves to RUN after writing entry DEPTH-1, so INIT lasts exactly DEPTH cycles.
  - init_done rises on the first RUN cycle and stays high until the next reset.
  - req_ready=0 throughout INIT.
- FSM RUN: no further transitions; only reset returns to INIT.
- Stage S0 (accept cycle t): issues a synchronous read of rd_idx.
  - rd_idx = (req_addr+OFFSET) mod DEPTH for COPY; req_addr for all other ops.
  - Captures op, write index, req_data.
- Stage S1 (cycle t+1): read data is available.
  - READ: no write; rsp = old entry.
  - ADD: writes old+req_data (wrap or clamp per SATURATE); rsp = old entry.
  - COPY: writes source value to req_addr; rsp = source value.
  - CLEAR: writes 0; rsp = old entry.
- Write and response-register load happen in the same cycle S1 advances.
- S1 advances when the response register is empty or rsp_ready=1.
- Latency: accepted at edge t -> rsp_valid high from cycle t+2 when there is no backpressure. Throughput is 1 request per cycle.
- Ordering: every request observes the writes of all earlier accepted requests.
  - S0 read of an index written by S1 in the same cycle returns the S1 write value (bypass).
  - Back-to-back ADDs to one index accumulate exactly.
  - An S1 request held by backpressure keeps its captured read data. S0 cannot accept meanwhile, so no hazard arises.
- req_ready = RUN and not (s1_valid and rsp_valid and not rsp_ready).
- At most 2 requests in flight: one in S1, one in the response register. Nothing is dropped or duplicated under any rsp_ready pattern.
- rsp_data is held stable while rsp_valid=1 and rsp_ready=0.
- COPY with source == target (OFFSET mod DEPTH == 0) rewrites the same value.
- Index arithmetic wraps mod DEPTH. Example: DEPTH=8, OFFSET=4, addr 6 -> source 2.
- Reset mid-operation:
  - In-flight requests are discarded with no response.
  - A write not yet performed must not occur.
  - INIT re-zeroes the whole table.

Decomposition:
- Shared package:
  - op encoding constants: OP_READ, OP_ADD, OP_COPY, OP_CLEAR.
  - FSM state constants: ST_INIT, ST_RUN.
  - the AW clog2 helper.
- One sub-module, rmw_table_ram: DEPTH x WIDTH, one synchronous read port, one write port, read-during-write returns new data.
- FSM, pipeline, bypass and handshake logic live in the top level.

Test Plan:
- Reset, hold rsp_ready=1 -> init_done rises after exactly 8 cycles; a READ of each index 0..7 returns 0.
- ADD 5 to idx 3 on 3 consecutive cycles -> responses 0, 5, 10; a following READ of idx 3 returns 15.
- ADD 7 to idx 1, then COPY idx 5 in the next cycle (source 1) -> COPY rsp=7; READ idx 5 returns 7.
- SATURATE=1, WIDTH=8: ADD 200 then ADD 100 to idx 0 -> READ returns 255. SATURATE=0 -> READ returns 44.
- rsp_ready=0 for 10 cycles while req_valid stays high -> exactly 2 requests accepted, req_ready=0 afterwards; all responses arrive in order once released.
- ADD 9 to idx 2 issued; reset_n pulsed low one cycle later -> no response appears; after re-INIT, READ idx 2 returns 0.
